// File: rtl/s_axil_reg_pkg.sv
// Shared response codes, FSM state types and address-window constants for the
// AXI4-Lite register responder.
package s_axil_reg_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam int IDX_LSB  = 2;
   localparam int WIN_BITS = 12;
   localparam int IDX_W    = WIN_BITS - IDX_LSB;

   typedef enum logic {W_IDLE, W_RESP} wr_state_e;
   typedef enum logic {R_IDLE, R_RESP} rd_state_e;

endpackage

// File: rtl/s_axil_strb_merge.sv
// Byte-strobe merge: each enabled byte of wdata replaces the matching byte of
// the old register word.
module s_axil_strb_merge (
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   output logic [31:0] new_word
);

   always_comb begin
      new_word = old_word;
      for (int b = 0; b < 4; b++) begin
         if (wstrb[b]) new_word[8*b +: 8] = wdata[8*b +: 8];
      end
   end

endmodule

// File: rtl/s_axil_reg_slave.sv
// AXI4-Lite register responder: NUM_REGS 32-bit words in a 4 KB window, one
// outstanding write and one outstanding read. Define AXIL_REG_SLAVE_DECERR_EN
// to report DECERR for out-of-range and SLVERR for read-only writes.
//
// state  | meaning
// W_IDLE | collecting AW and W in any order; commit when both are held
// W_RESP | bvalid high, AW/W blocked until bready
// R_IDLE | arready high; rdata captured on the AR handshake
// R_RESP | rvalid high, rdata/rresp frozen until rready
module s_axil_reg_slave
   import s_axil_reg_pkg::*;
#(
   parameter int                  NUM_REGS = 8,
   parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
   input  logic                     aclk,
   input  logic                     reset,
   input  logic [31:0]              awaddr,
   input  logic                     awvalid,
   output logic                     awready,
   input  logic [31:0]              wdata,
   input  logic [3:0]               wstrb,
   input  logic                     wvalid,
   output logic                     wready,
   output logic [1:0]               bresp,
   output logic                     bvalid,
   input  logic                     bready,
   input  logic [31:0]              araddr,
   input  logic                     arvalid,
   output logic                     arready,
   output logic [31:0]              rdata,
   output logic [1:0]               rresp,
   output logic                     rvalid,
   input  logic                     rready,
   output logic [32*NUM_REGS-1:0]   regs_o,
   output logic [NUM_REGS-1:0]      wr_pulse_o,
   input  logic [32*NUM_REGS-1:0]   status_i
);

   wr_state_e         wr_state;
   rd_state_e         rd_state;
   logic              aw_held, w_held;
   logic [IDX_W-1:0]  aw_idx_q;
   logic [31:0]       wdata_q;
   logic [3:0]        wstrb_q;
   logic [31:0]       regs_q [NUM_REGS];

   logic              aw_fire, w_fire, commit;
   logic [IDX_W-1:0]  w_idx, r_idx;
   logic [31:0]       w_data, old_word, new_word, rd_word;
   logic [3:0]        w_strb;
   logic [1:0]        w_resp, r_resp;
   logic              unused_addr_bits;

   // Readies are gated by reset so every output reads 0 while reset is high.
   assign awready = (wr_state == W_IDLE) && !aw_held && !reset;
   assign wready  = (wr_state == W_IDLE) && !w_held && !reset;
   assign arready = (rd_state == R_IDLE) && !reset;
   assign bvalid  = (wr_state == W_RESP);
   assign rvalid  = (rd_state == R_RESP);

   assign aw_fire = awvalid && awready;
   assign w_fire  = wvalid && wready;
   assign commit  = (wr_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);

   // Same-cycle handshakes bypass the holding registers.
   assign w_idx  = aw_fire ? awaddr[WIN_BITS-1:IDX_LSB] : aw_idx_q;
   assign w_data = w_fire ? wdata : wdata_q;
   assign w_strb = w_fire ? wstrb : wstrb_q;
   assign r_idx  = araddr[WIN_BITS-1:IDX_LSB];

   assign unused_addr_bits = ^{awaddr[31:WIN_BITS], awaddr[IDX_LSB-1:0],
                               araddr[31:WIN_BITS], araddr[IDX_LSB-1:0]};

   always_comb begin
      old_word = '0;
      rd_word  = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (w_idx == IDX_W'(i)) old_word = regs_q[i];
         if (r_idx == IDX_W'(i)) rd_word = RO_MASK[i] ? status_i[32*i +: 32] : regs_q[i];
      end
   end

   s_axil_strb_merge u_merge (
      .old_word (old_word),
      .wdata    (w_data),
      .wstrb    (w_strb),
      .new_word (new_word)
   );

`ifdef AXIL_REG_SLAVE_DECERR_EN
   logic w_is_ro, w_in_range, r_in_range;

   assign w_in_range = int'(w_idx) < NUM_REGS;
   assign r_in_range = int'(r_idx) < NUM_REGS;

   always_comb begin
      w_is_ro = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (w_idx == IDX_W'(i)) w_is_ro = RO_MASK[i];
      end
   end

   assign w_resp = !w_in_range ? RESP_DECERR : (w_is_ro ? RESP_SLVERR : RESP_OKAY);
   assign r_resp = r_in_range ? RESP_OKAY : RESP_DECERR;
`else
   assign w_resp = RESP_OKAY;
   assign r_resp = RESP_OKAY;
`endif

   always_ff @(posedge aclk) begin
      if (reset) begin
         wr_state   <= W_IDLE;
         aw_held    <= 1'b0;
         w_held     <= 1'b0;
         aw_idx_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bresp      <= RESP_OKAY;
         wr_pulse_o <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         wr_pulse_o <= '0;
         case (wr_state)
            W_IDLE: begin
               if (aw_fire) begin
                  aw_held  <= 1'b1;
                  aw_idx_q <= awaddr[WIN_BITS-1:IDX_LSB];
               end
               if (w_fire) begin
                  w_held  <= 1'b1;
                  wdata_q <= wdata;
                  wstrb_q <= wstrb;
               end
               if (commit) begin
                  wr_state <= W_RESP;
                  bresp    <= w_resp;
                  // Out-of-range indices match no slot: no pulse, no update.
                  for (int i = 0; i < NUM_REGS; i++) begin
                     if (w_idx == IDX_W'(i)) begin
                        wr_pulse_o[i] <= 1'b1;
                        if (!RO_MASK[i]) regs_q[i] <= new_word;
                     end
                  end
               end
            end
            W_RESP: begin
               if (bready) begin
                  wr_state <= W_IDLE;
                  bresp    <= RESP_OKAY;
                  aw_held  <= 1'b0;
                  w_held   <= 1'b0;
               end
            end
            default: wr_state <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         rd_state <= R_IDLE;
         rdata    <= '0;
         rresp    <= RESP_OKAY;
      end else begin
         case (rd_state)
            R_IDLE: begin
               if (arvalid) begin
                  rd_state <= R_RESP;
                  rdata    <= rd_word;
                  rresp    <= r_resp;
               end
            end
            R_RESP: begin
               if (rready) rd_state <= R_IDLE;
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
      assign regs_o[32*g +: 32] = regs_q[g];
   end

endmodule

// File: tb/tb_s_axil_reg_slave.sv
// Directed bench for s_axil_reg_slave: a transaction-level model of the
// register file and channel handshakes is checked every cycle, plus literals.
module tb_s_axil_reg_slave;

   localparam int          N  = 8;
   localparam logic [N-1:0] RO = 8'h04;
`ifdef AXIL_REG_SLAVE_DECERR_EN
   localparam logic [1:0] EXP_DEC = 2'b11;
   localparam logic [1:0] EXP_SLV = 2'b10;
`else
   localparam logic [1:0] EXP_DEC = 2'b00;
   localparam logic [1:0] EXP_SLV = 2'b00;
`endif

   logic aclk, reset;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic awvalid, awready, wvalid, wready, bvalid, bready;
   logic arvalid, arready, rvalid, rready;
   logic [3:0] wstrb;
   logic [1:0] bresp, rresp;
   logic [32*N-1:0] regs_o, status_i;
   logic [N-1:0] wr_pulse_o;

   s_axil_reg_slave #(.NUM_REGS(N), .RO_MASK(RO)) dut (
      .aclk(aclk), .reset(reset),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .regs_o(regs_o), .wr_pulse_o(wr_pulse_o), .status_i(status_i)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_regs [N];
   bit          m_aw_held, m_w_held, m_bvalid, m_rvalid, started;
   int          m_aw_idx;
   logic [31:0] m_wdata, m_rdata;
   logic [3:0]  m_wstrb;
   logic [1:0]  m_bresp, m_rresp;
   logic [N-1:0] m_pulse;

   function automatic logic [1:0] exp_wresp(input int idx);
      if (idx >= N) return EXP_DEC;
      if (RO[idx]) return EXP_SLV;
      return 2'b00;
   endfunction

   function automatic logic [31:0] model_read(input int idx);
      if (idx >= N) return 32'h0;
      if (RO[idx]) return status_i[32*idx +: 32];
      return m_regs[idx];
   endfunction

   // Compare the current cycle, then advance the model across the next edge.
   always @(negedge aclk) begin
      bit aw_f, w_f;
      int ridx;
      if (started) begin
         chk("awready", 32'(awready), 32'(!reset && !m_bvalid && !m_aw_held));
         chk("wready",  32'(wready),  32'(!reset && !m_bvalid && !m_w_held));
         chk("arready", 32'(arready), 32'(!reset && !m_rvalid));
         chk("bvalid",  32'(bvalid),  32'(m_bvalid));
         chk("rvalid",  32'(rvalid),  32'(m_rvalid));
         chk("wr_pulse", 32'(wr_pulse_o), 32'(m_pulse));
         if (m_bvalid) chk("bresp", 32'(bresp), 32'(m_bresp));
         if (m_rvalid) begin
            chk("rdata", rdata, m_rdata);
            chk("rresp", 32'(rresp), 32'(m_rresp));
         end
         for (int i = 0; i < N; i++)
            chk($sformatf("regs_o[%0d]", i), regs_o[32*i +: 32], m_regs[i]);
      end
      if (reset) begin
         for (int i = 0; i < N; i++) m_regs[i] = '0;
         m_aw_held = 0; m_w_held = 0; m_bvalid = 0; m_rvalid = 0;
         m_pulse = '0; started = 1;
      end else begin
         m_pulse = '0;
         // Read first so a colliding read sees the pre-write value.
         if (m_rvalid) begin
            if (rready) m_rvalid = 0;
         end else if (arvalid) begin
            ridx = int'(araddr[11:2]);
            m_rdata  = model_read(ridx);
            m_rresp  = (ridx >= N) ? EXP_DEC : 2'b00;
            m_rvalid = 1;
         end
         if (m_bvalid) begin
            if (bready) begin
               m_bvalid = 0; m_aw_held = 0; m_w_held = 0;
            end
         end else begin
            aw_f = awvalid && !m_aw_held;
            w_f  = wvalid && !m_w_held;
            if (aw_f) begin m_aw_held = 1; m_aw_idx = int'(awaddr[11:2]); end
            if (w_f)  begin m_w_held = 1; m_wdata = wdata; m_wstrb = wstrb; end
            if (m_aw_held && m_w_held) begin
               if (m_aw_idx < N) begin
                  m_pulse[m_aw_idx] = 1'b1;
                  if (!RO[m_aw_idx])
                     for (int b = 0; b < 4; b++)
                        if (m_wstrb[b]) m_regs[m_aw_idx][8*b +: 8] = m_wdata[8*b +: 8];
               end
               m_bresp  = exp_wresp(m_aw_idx);
               m_bvalid = 1;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic rdy(input int which);
      case (which)
         0: return awready;
         1: return wready;
         default: return arready;
      endcase
   endfunction

   task automatic hs_wait(input string name, input int which);
      bit ok = 0;
      for (int k = 0; k < 50; k++) begin
         @(posedge aclk);
         if (rdy(which)) begin ok = 1; break; end
      end
      n_vec++;
      if (!ok) begin n_bad++; $display("FAIL %s handshake: got timeout, expected ready", name); end
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            output logic [1:0] resp);
      bit ok = 0;
      fork
         begin
            repeat (aw_dly) @(posedge aclk);
            #2 awaddr = addr; awvalid = 1;
            hs_wait("aw", 0);
            #2 awvalid = 0;
         end
         begin
            repeat (w_dly) @(posedge aclk);
            #2 wdata = data; wstrb = strb; wvalid = 1;
            hs_wait("w", 1);
            #2 wvalid = 0;
         end
      join
      resp = 2'bxx;
      for (int k = 0; k < 50; k++) begin
         @(posedge aclk);
         if (bvalid && bready) begin ok = 1; resp = bresp; break; end
      end
      n_vec++;
      if (!ok) begin n_bad++; $display("FAIL b handshake: got timeout, expected bvalid"); end
      #2;
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
      bit ok = 0;
      #2 araddr = addr; arvalid = 1;
      hs_wait("ar", 2);
      #2 arvalid = 0;
      data = 'x; resp = 'x;
      for (int k = 0; k < 50; k++) begin
         @(posedge aclk);
         if (rvalid && rready) begin ok = 1; data = rdata; resp = rresp; break; end
      end
      n_vec++;
      if (!ok) begin n_bad++; $display("FAIL r handshake: got timeout, expected rvalid"); end
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got time limit, expected $finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed vectors ----------------
   initial begin
      logic [31:0] d;
      logic [1:0]  r, r2;
      reset = 1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
      awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
      for (int i = 0; i < N; i++) status_i[32*i +: 32] = 32'hBAD0_0000 | 32'(i);
      status_i[32*2 +: 32] = 32'hCAFE_0002;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      chk("reset bvalid", 32'(bvalid), 32'h0);
      chk("reset regs_o", regs_o[31:0] | regs_o[255:224], 32'h0);
      @(posedge aclk); #2 reset = 0;
      @(negedge aclk);
      chk("ready after reset", 32'({awready, wready, arready}), 32'h7);
      @(posedge aclk); #2;

      // AW and W together, then read back and via aliased address bits.
      axi_write(32'h0000_000C, 32'hDEAD_BEEF, 4'hF, 0, 0, r);
      chk("wr3 bresp", 32'(r), 32'h0);
      axi_read(32'h0000_000C, d, r);
      chk("rd3 data", d, 32'hDEAD_BEEF);
      axi_read(32'hFFFF_F00F, d, r);
      chk("rd3 alias", d, 32'hDEAD_BEEF);

      // W four cycles ahead of AW.
      axi_write(32'h4, 32'h1234_5678, 4'hF, 4, 0, r);
      chk("reg1 regs_o", regs_o[63:32], 32'h1234_5678);

      // Partial strobe and zero strobe.
      axi_write(32'h0, 32'hFFFF_FFFF, 4'hF, 0, 0, r);
      axi_write(32'h0, 32'h0000_0000, 4'h5, 0, 2, r);
      axi_read(32'h0, d, r);
      chk("strb 0x5", d, 32'hFF00_FF00);
      axi_write(32'h0, 32'h1212_1212, 4'h0, 0, 0, r);
      axi_read(32'h0, d, r);
      chk("strb 0x0", d, 32'hFF00_FF00);

      // Out-of-range and read-only slot.
      axi_write(32'h20, 32'h5555_5555, 4'hF, 0, 0, r);
      chk("oor bresp", 32'(r), 32'(EXP_DEC));
      axi_read(32'h20, d, r);
      chk("oor rdata", d, 32'h0);
      chk("oor rresp", 32'(r), 32'(EXP_DEC));
      axi_write(32'h8, 32'h1111_1111, 4'hF, 0, 0, r);
      chk("ro bresp", 32'(r), 32'(EXP_SLV));
      axi_read(32'h8, d, r);
      chk("ro rdata", d, 32'hCAFE_0002);
      chk("ro rresp", 32'(r), 32'h0);
      axi_write(32'h10, 32'hA5A5_0004, 4'hF, 0, 0, r);
      axi_read(32'h10, d, r);
      chk("rw reg4", d, 32'hA5A5_0004);

      // Backpressure on B and R.
      bready = 0;
      fork
         axi_write(32'h18, 32'h0BAD_F00D, 4'hF, 0, 0, r);
         begin repeat (12) @(posedge aclk); #2 bready = 1; end
      join
      rready = 0;
      fork
         axi_read(32'h18, d, r);
         begin repeat (12) @(posedge aclk); #2 rready = 1; end
      join
      chk("bp rdata", d, 32'h0BAD_F00D);

      // Read/write collision on reg 5.
      axi_write(32'h14, 32'h1, 4'hF, 0, 0, r);
      fork
         axi_write(32'h14, 32'h2, 4'hF, 0, 0, r2);
         axi_read(32'h14, d, r);
      join
      chk("collide rdata", d, 32'h1);
      axi_read(32'h14, d, r);
      chk("after collide", d, 32'h2);

      // Reset while the write response is pending.
      bready = 0;
      #2 awaddr = 32'hC; wdata = 32'h7777_7777; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      hs_wait("aw+w", 0);
      #2 awvalid = 0; wvalid = 0;
      @(negedge aclk);
      chk("bvalid pre-reset", 32'(bvalid), 32'h1);
      @(posedge aclk); #2 reset = 1;
      @(posedge aclk); #2 reset = 0; bready = 1;
      @(negedge aclk);
      chk("bvalid post-reset", 32'(bvalid), 32'h0);
      chk("reg3 post-reset", regs_o[127:96], 32'h0);
      @(posedge aclk); #2;
      axi_read(32'hC, d, r);
      chk("rd3 post-reset", d, 32'h0);

      repeat (3) @(posedge aclk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/s_axil_reg_slave.md
# s_axil_reg_slave

AXI4-Lite register responder: the endpoint that terminates one master slot of the AXI-Lite crossbar (e.g. the 0x0000 or 0x1000 4 KB window) and maps it onto NUM_REGS 32-bit registers. It supports:
- independent AW/W channel acceptance, byte strobes and read-only status slots;
- one outstanding write and one outstanding read.

## Interface
Parameters:
- NUM_REGS, 8, number of 32-bit word registers, 1..1024, decoded from addr[11:2].
- RO_MASK, '0 (NUM_REGS bits), bit i=1 makes register i read-only; it reads status_i word i.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - aclk  in  1  clock.
  - reset  in  1  synchronous, active-high.
- Write address channel:
  - awaddr  in  32  write address.
  - awvalid  in  1.
  - awready  out  1.
- Write data channel:
  - wdata  in  32.
  - wstrb  in  4  byte enables.
  - wvalid  in  1.
  - wready  out  1.
- Write response channel:
  - bresp  out  2.
  - bvalid  out  1.
  - bready  in  1.
- Read address channel:
  - araddr  in  32.
  - arvalid  in  1.
  - arready  out  1.
- Read data channel:
  - rdata  out  32.
  - rresp  out  2.
  - rvalid  out  1.
  - rready  in  1.
- User-logic side:
  - regs_o  out  32*NUM_REGS  current register contents; word i at [32*i +: 32].
  - wr_pulse_o  out  NUM_REGS  one-cycle pulse per committed write to register i.
  - status_i  in  32*NUM_REGS  read values for RO slots; sampled at AR handshake.

## Operation
- Address decode: index = addr[11:2]. addr[31:12] and addr[1:0] are ignored. The index is in range iff index < NUM_REGS.
- Write FSM states: W_IDLE, W_RESP.
  - W_IDLE: awready = !aw_held, wready = !w_held.
  - Each handshake latches its payload and sets its held flag. AW and W may arrive in either order or in the same cycle.
  - On the edge where both are held (or both handshake together), the write commits and the FSM goes to W_RESP.
  - Commit: for each byte b with wstrb[b]=1, reg[index][8b+7:8b] <= wdata[8b+7:8b].
  - wr_pulse_o[index] = 1 for exactly the next cycle. This applies for RO and out-of-range writes too, except that wr_pulse_o stays 0 for out-of-range writes.
  - RO or out-of-range writes leave the register unchanged.
  - W_RESP: bvalid = 1, awready = wready = 0. bvalid stays high with bresp stable until bready. Then the held flags clear and the FSM returns to W_IDLE.
- Read FSM states: R_IDLE, R_RESP.
  - R_IDLE: arready = 1. On arvalid, rdata is loaded and the FSM goes to R_RESP. rdata = status_i word if RO_MASK[index], else reg[index]; 0 if out of range.
  - R_RESP: rvalid = 1, arready = 0. rdata/rresp hold until rready, then R_IDLE.
- Read/write collision: a read handshake in the same cycle as a write commit to the same index returns the pre-write value.
- The read and write paths are fully independent.
- wstrb = 0: the write commits with no byte change, and wr_pulse_o still fires.

## Timing
- Reset values (while reset is high and on the first cycle after): all outputs 0, regs_o = 0, both FSMs idle, held flags clear.
- After reset: awready = wready = arready = 1 from the first non-reset cycle.
- Write latency: bvalid is asserted the cycle after the commit edge. With bready tied high, the next AW/W is accepted 2 cycles after the previous commit.
- Read latency: rvalid is asserted the cycle after the AR handshake. With rready high, arready returns the following cycle.
- regs_o reflects a write in the same cycle bvalid rises.
- Reset asserted mid-transaction: all state is dropped, and no response is issued for the in-flight transaction.

## Configuration
- AXIL_REG_SLAVE_DECERR_EN:
  - Defined: out-of-range accesses return bresp/rresp = 2'b11 (DECERR). Writes to RO slots return 2'b10 (SLVERR).
  - Undefined: every response is 2'b00 (OKAY). Out-of-range reads return 0, and ignored writes are silent.

## Structure
- Package s_axil_reg_pkg holds:
  - the response codes: RESP_OKAY, RESP_SLVERR, RESP_DECERR;
  - the enums: wr_state_e {W_IDLE, W_RESP} and rd_state_e {R_IDLE, R_RESP};
  - the constants IDX_LSB = 2 and WIN_BITS = 12.
- One sub-module, s_axil_strb_merge: combinational merge of old word, wdata and wstrb into the new word.

## Test plan
- Write-then-read, AW and W in the same cycle: reg 3 <= 0xDEADBEEF, wstrb 0xF → bvalid 1 cycle later with OKAY. Read of addr 0xC → rvalid 1 cycle after AR, rdata 0xDEADBEEF.
- W 4 cycles before AW: reg 1 <= 0x12345678 → commit only on the AW handshake, wr_pulse_o[1] high 1 cycle, regs_o word 1 = 0x12345678.
- Partial strobe: reg 0 = 0xFFFFFFFF, write 0x00000000 with wstrb 0x5 → reads 0xFF00FF00.
- Out-of-range (NUM_REGS = 8, addr 0x20) and RO slot (RO_MASK = 0x4, status_i word 2 = 0xCAFE0002):
  - with the macro defined: read of 0x20 → DECERR, rdata 0; write of 0x8 → SLVERR; read of 0x8 → 0xCAFE0002.
  - without the macro: all responses OKAY.
- Backpressure: bready held low for 10 cycles → bvalid/bresp stable, awready = wready = 0 throughout. Same check for rready low with rvalid/rdata.
- Read/write collision and reset:
  - AR to reg 5 in the same cycle as a write commit to reg 5 (old 0x1, new 0x2) → rdata 0x1.
  - Reset asserted during W_RESP → all outputs 0 on the next cycle, registers cleared.
